// File: rtl/or_reduce_sequencer.sv
// Serial OR reducer: folds NUM_OPS operands through one 2-input OR stage.
// Result is registered one cycle after the last operand and held until consumed.
module or_reduce_sequencer #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_OPS = 4,
  localparam int CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  generate
    if (NUM_OPS < 2) begin : g_bad_num_ops
      $error("or_reduce_sequencer: NUM_OPS must be >= 2");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ACCUM = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             in_fire;

  // clear blocks acceptance so an abort cycle can never also start a reduction
  assign in_ready = !clear && (state_q != HOLD);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            acc_d   = in_data;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc_d = acc_q | in_data;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              out_data_d  = acc_q | in_data;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_or_reduce_sequencer.sv
// Bench for or_reduce_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_or_reduce_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;
  logic [2:0] op_count;

  logic        clear2, in_valid2, out_ready2;
  logic [15:0] in_data2;
  logic        in_ready2, out_valid2, busy2;
  logic [15:0] out_data2;
  logic [1:0]  op_count2;

  always #5 clk = ~clk;

  or_reduce_sequencer #(.WIDTH(8), .NUM_OPS(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .op_count(op_count)
  );

  or_reduce_sequencer #(.WIDTH(16), .NUM_OPS(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .busy(busy2), .op_count(op_count2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: operands collected so far, and the held result if any.
  logic [7:0] mq[$];
  bit         m_held;
  logic [7:0] m_res;

  function automatic logic [7:0] or_all();
    logic [7:0] r = 8'h00;
    foreach (mq[i]) r = r | mq[i];
    return r;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_held = 1'b0;
    m_res  = 8'h00;
  endtask

  // One clock cycle on dut: drive, check against model, clock, update model.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy, input logic clr);
    bit rdy;
    int cnt;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clear     = clr;
    #1;
    rdy = !clr && !m_held;
    cnt = m_held ? 4 : mq.size();
    chk("in_ready",  in_ready,  rdy);
    chk("out_valid", out_valid, m_held);
    chk("out_data",  out_data,  m_res);
    chk("busy",      busy,      m_held || (mq.size() > 0));
    chk("op_count",  op_count,  cnt);
    @(posedge clk);
    if (clr) begin
      mq.delete();
      m_held = 1'b0;
    end else if (m_held) begin
      if (ordy) m_held = 1'b0;
    end else if (iv) begin
      mq.push_back(id);
      if (mq.size() == 4) begin
        m_res  = or_all();
        m_held = 1'b1;
        mq.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic feed4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    cyc(1'b1, a, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b0);
    cyc(1'b1, c, 1'b0, 1'b0);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] ops3[4];
    ops3[0] = 8'h10; ops3[1] = 8'h20; ops3[2] = 8'h40; ops3[3] = 8'h08;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    clear2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; in_data2 = 16'h0000;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vld",  out_valid, 1'b0);
    chk("rst_cnt",  op_count, 3'd0);
    chk("rst_data", out_data, 8'h00);
    rst = 1'b0;

    // 16-bit, two-operand instance
    in_valid2 = 1'b1; in_data2 = 16'h0000;
    @(negedge clk);
    chk("n2_vld_early", out_valid2, 1'b0);
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("n2_vld_a", out_valid2, 1'b1);
    chk("n2_dat_a", out_data2, 16'h0000);
    @(negedge clk);
    chk("n2_vld_drop", out_valid2, 1'b0);
    in_valid2 = 1'b1; in_data2 = 16'hFFFF;
    @(negedge clk);
    in_data2 = 16'h0001;
    chk("n2_cnt", op_count2, 2'd1);
    chk("n2_vld_mid", out_valid2, 1'b0);
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("n2_vld_b", out_valid2, 1'b1);
    chk("n2_dat_b", out_data2, 16'hFFFF);
    chk("n2_cnt_hold", op_count2, 2'd2);
    @(negedge clk);
    chk("n2_busy_end", busy2, 1'b0);

    // Test 1: back-to-back, consumer ready
    cyc(1'b1, 8'h01, 1'b1, 1'b0);
    cyc(1'b1, 8'h02, 1'b1, 1'b0);
    cyc(1'b1, 8'h04, 1'b1, 1'b0);
    cyc(1'b1, 8'h80, 1'b1, 1'b0);
    chk("t1_vld", out_valid, 1'b1);
    chk("t1_dat", out_data, 8'h87);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_vld_one", out_valid, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // Test 2: stalled consumer with input pressure
    feed4(8'h01, 8'h02, 8'h04, 8'h80);
    repeat (5) cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t2_dat_stable", out_data, 8'h87);
    chk("t2_rdy", in_ready, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t2_restart_cnt", op_count, 3'd1);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    chk("t2_dat_ff", out_data, 8'hFF);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Test 3: gaps between operands
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 3)) cyc(1'b0, 8'hAA, 1'b0, 1'b0);
      cyc(1'b1, ops3[k], 1'b0, 1'b0);
      if (k < 3) chk("t3_cnt", op_count, k + 1);
    end
    chk("t3_dat", out_data, 8'h78);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Test 4: clear mid-reduction, then clear during hold
    cyc(1'b1, 8'hF0, 1'b0, 1'b0);
    cyc(1'b1, 8'h0F, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("t4_cnt", op_count, 3'd0);
    feed4(8'h00, 8'h00, 8'h00, 8'h00);
    chk("t4_dat", out_data, 8'h00);
    chk("t4_vld", out_valid, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t4_clr_hold", out_valid, 1'b0);

    // Test 5: async reset mid-reduction
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    chk("t5_cnt_pre", op_count, 3'd2);
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_cnt",  op_count, 3'd0);
    chk("t5_vld",  out_valid, 1'b0);
    rst = 1'b0;
    m_reset();
    feed4(8'h03, 8'h03, 8'h03, 8'h03);
    chk("t5_dat", out_data, 8'h03);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
